floo_output_port: RTL and testbench
===================================

// Module: floo_output_port
//
// PURPOSE
// Transmit side of the VC router link; the counterpart of the downstream input port. Holds one
// credit counter per downstream VC, sized to that VC's buffer depth. Registers the flit
// granted by switch allocation onto the link and stamps its VC id into the header. Consumes
// the returned credit stream, and exposes per-VC credit availability to the VA/SA stages.
//
// PARAMETERS
// flit_t         logic  link flit type; must contain hdr.vc_id
// hdr_t          logic  flit header type
// NumVC          4      number of virtual channels on the link
// NumVCWidth     2      width of VC id; 2**NumVCWidth >= NumVC
// VCDepth        3      downstream buffer depth (flits) of every VC except DeeperVCId
// DeeperVCId     0      index of the VC with a different buffer depth
// DeeperVCDepth  2      downstream buffer depth of VC DeeperVCId
// CntWidth       $clog2(max(VCDepth,DeeperVCDepth)+1)  credit counter width (derived)
//
// PORTS
// clk_i              in   1           clock
// rst_ni             in   1           asynchronous reset, active-low
// credit_v_i         in   1           credit return valid from downstream input port
// credit_id_i        in   NumVCWidth  VC id of returned credit
// send_v_i           in   1           SA/ST stage sends a flit this cycle
// send_vc_id_i       in   NumVCWidth  downstream VC allocated to the flit
// send_flit_i        in   flit_t      flit to transmit
// data_v_o           out  1           flit valid on link
// data_o             out  flit_t      flit on link; hdr.vc_id = VC of this flit
// vc_credit_v_o      out  NumVC       per-VC: counter != 0
// vc_credit_gt1_o    out  NumVC       per-VC: counter >= 2 (for back-to-back allocation)
// vc_idle_o          out  NumVC       per-VC: counter == full depth (no flits in flight)
//
// BEHAVIOUR
// - Reset: counters[v] = (v==DeeperVCId ? DeeperVCDepth : VCDepth); data_v_o=0, data_o='0.
//   All status outputs are therefore reset-true (vc_credit_gt1_o[v] true iff depth>=2).
// - Send: data_v_o/data_o are registered; latency 1 cycle from send_v_i. data_o is
//   send_flit_i with hdr.vc_id[NumVCWidth-1:0] replaced by send_vc_id_i. If send_v_i=0 in a
//   cycle, data_v_o=0 the next cycle; data_o holds its last value.
// - Counter next-state, per VC v: dec = send_v_i & (send_vc_id_i==v) & counter!=0;
//   inc = credit_v_i & (credit_id_i==v). inc&dec -> unchanged; dec only -> -1; inc only -> +1.
// - Send on a VC with counter==0 is illegal: assertion fires; the flit is dropped (data_v_o=0,
//   no decrement).
// - Credit return to a VC already at full depth is illegal: assertion fires; counter saturates.
// - send_vc_id_i / credit_id_i >= NumVC is illegal: assertion fires; event ignored.
// - Status outputs are combinational decodes of the counter registers only (no bypass of
//   this cycle's inc/dec). A credit returned in cycle t is visible in cycle t+1.
// - Counter width arithmetic is in CntWidth; no wrap-around is possible given the rules above.
// - Reset asserted mid-traffic restores full credits. The downstream input port is on the same
//   reset domain, and its buffers are flushed together.
//
// STRUCTURE
// - No new package content; flit_t/hdr_t come from the existing router typedefs.
// - One sub-module: floo_vc_credit_counter (params: Depth, CntWidth; ports clk_i, rst_ni,
//   inc_i, dec_i, cnt_o, credit_v_o, gt1_o, idle_o, plus overflow/underflow assertions).
//   Instantiate it NumVC times with Depth chosen per DeeperVCId.
// - The top level holds the one-hot decode of send/credit ids, the output flit register,
//   and the assertions.
//
// TESTING
// 1 Reset, NumVC=4, VCDepth=3, DeeperVCId=0, DeeperVCDepth=2 -> vc_credit_v_o=4'b1111,
//   vc_idle_o=4'b1111, vc_credit_gt1_o=4'b1111, data_v_o=0.
// 2 Three sends on VC2 in cycles 0..2, no credits -> data_v_o high in cycles 1..3 with
//   hdr.vc_id=2. vc_credit_gt1_o[2]=0 from cycle 2, vc_credit_v_o[2]=0 from cycle 3.
// 3 VC2 at 0, credit_v_i on VC2 in cycle t -> vc_credit_v_o[2]=1 at t+1. A send on VC2 at t+1
//   is accepted.
// 4 VC1 at 1, send on VC1 and credit on VC1 in the same cycle -> counter stays 1,
//   vc_credit_v_o[1]=1, the flit goes out.
// 5 Send on VC0 with counter 0 -> assertion fires, data_v_o=0, counter stays 0.
//   Separately, a credit on VC3 at full depth -> assertion fires, counter stays 3.
// 6 Random sends gated by vc_credit_v_o, with a scoreboarded model of the downstream
//   input port returning credits after random 1..5 cycle delay -> no assertion fires.
//   Every counter returns to depth (vc_idle_o all ones) after drain. Mid-run rst_ni pulse
//   -> all counters return to depth.

Source files
------------

// File: rtl/floo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : floo_pkg
// Description : Router link typedefs shared by the output port and its counters.
// Revision    : 1.0 - initial release
// ============================================================================
package floo_pkg;

    localparam int c_vc_id_width = 3;

    typedef struct packed {
        logic [c_vc_id_width-1:0] vc_id;
        logic [7:0]               dst;
        logic                     last;
    } hdr_t;

    typedef struct packed {
        hdr_t        hdr;
        logic [31:0] payload;
    } flit_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/floo_vc_credit_counter.sv
`default_nettype none
// ============================================================================
// Module      : floo_vc_credit_counter
// Description : Credit counter for one downstream VC buffer, with status decodes.
// Revision    : 1.0 - initial release
// ============================================================================
module floo_vc_credit_counter #(
    parameter int DEPTH     = 3,
    parameter int CNT_WIDTH = 2,
    parameter bit ASSERT_EN = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 inc_i,
    input  logic                 dec_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 credit_v_o,
    output logic                 gt1_o,
    output logic                 idle_o
);

    localparam logic [CNT_WIDTH-1:0] c_depth = CNT_WIDTH'(DEPTH);

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;

    // Simultaneous inc/dec cancel; a credit at full depth saturates.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (inc_i && !dec_i && (r_cnt != c_depth)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end else if (dec_i && !inc_i && (r_cnt != '0)) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= c_depth;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign cnt_o      = r_cnt;
    assign credit_v_o = (r_cnt != '0);
    assign gt1_o      = (r_cnt > CNT_WIDTH'(1));
    assign idle_o     = (r_cnt == c_depth);

    if (ASSERT_EN) begin : g_assert
        always @(posedge clk_i) begin
            if (rst_ni) begin
                a_overflow: assert (!(inc_i && !dec_i && (r_cnt == c_depth)))
                    else $error("credit counter overflow");
                a_underflow: assert (!(dec_i && (r_cnt == '0)))
                    else $error("credit counter underflow");
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/floo_output_port.sv
`default_nettype none
// ============================================================================
// Module      : floo_output_port
// Description : VC link transmitter: per-VC credit counters and registered flit output.
// Revision    : 1.0 - initial release
// ============================================================================
module floo_output_port
    import floo_pkg::*;
#(
    parameter type FLIT_T          = flit_t,
    parameter type HDR_T           = hdr_t,
    parameter int  NUM_VC          = 4,
    parameter int  NUM_VC_WIDTH    = 2,
    parameter int  VC_DEPTH        = 3,
    parameter int  DEEPER_VC_ID    = 0,
    parameter int  DEEPER_VC_DEPTH = 2,
    parameter bit  ASSERT_EN       = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    credit_v_i,
    input  logic [NUM_VC_WIDTH-1:0] credit_id_i,
    input  logic                    send_v_i,
    input  logic [NUM_VC_WIDTH-1:0] send_vc_id_i,
    input  FLIT_T                   send_flit_i,
    output logic                    data_v_o,
    output FLIT_T                   data_o,
    output logic [NUM_VC-1:0]       vc_credit_v_o,
    output logic [NUM_VC-1:0]       vc_credit_gt1_o,
    output logic [NUM_VC-1:0]       vc_idle_o
);

    localparam int c_cnt_width = $clog2(max_int(VC_DEPTH, DEEPER_VC_DEPTH) + 1);

    logic [NUM_VC-1:0]      w_send_hit;
    logic [NUM_VC-1:0]      w_credit_hit;
    logic [NUM_VC-1:0]      w_dec;
    logic [NUM_VC-1:0]      w_inc;
    logic [NUM_VC-1:0]      w_full;
    logic [c_cnt_width-1:0] w_cnt [NUM_VC];
    logic                   w_send_ok;
    HDR_T                   w_hdr;
    FLIT_T                  w_flit;
    logic                   r_data_v;
    FLIT_T                  r_data;

    // Ids outside 0..NUM_VC-1 match no slot and are therefore ignored.
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        localparam int c_depth = (v == DEEPER_VC_ID) ? DEEPER_VC_DEPTH : VC_DEPTH;

        assign w_send_hit[v]   = (send_vc_id_i == NUM_VC_WIDTH'(v));
        assign w_credit_hit[v] = (credit_id_i == NUM_VC_WIDTH'(v));
        assign w_dec[v]        = send_v_i & w_send_hit[v] & vc_credit_v_o[v];
        assign w_inc[v]        = credit_v_i & w_credit_hit[v];
        assign w_full[v]       = (w_cnt[v] == c_cnt_width'(c_depth));

        floo_vc_credit_counter #(
            .DEPTH     (c_depth),
            .CNT_WIDTH (c_cnt_width),
            .ASSERT_EN (ASSERT_EN)
        ) u_credit_cnt (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .inc_i      (w_inc[v]),
            .dec_i      (w_dec[v]),
            .cnt_o      (w_cnt[v]),
            .credit_v_o (vc_credit_v_o[v]),
            .gt1_o      (vc_credit_gt1_o[v]),
            .idle_o     (vc_idle_o[v])
        );
    end

    // A flit is only launched when its VC holds a credit; otherwise it is dropped.
    assign w_send_ok = |w_dec;

    always_comb begin
        w_hdr                          = send_flit_i.hdr;
        w_hdr.vc_id[NUM_VC_WIDTH-1:0]  = send_vc_id_i;
        w_flit                         = send_flit_i;
        w_flit.hdr                     = w_hdr;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data_v <= 1'b0;
            r_data   <= '0;
        end else begin
            r_data_v <= w_send_ok;
            if (w_send_ok) begin
                r_data <= w_flit;
            end
        end
    end

    assign data_v_o = r_data_v;
    assign data_o   = r_data;

    if (ASSERT_EN) begin : g_assert
        always @(posedge clk_i) begin
            if (rst_ni) begin
                a_send_no_credit: assert (!(send_v_i && |(w_send_hit & ~vc_credit_v_o)))
                    else $error("send on VC without credit");
                a_send_id_range: assert (!(send_v_i && !(|w_send_hit)))
                    else $error("send VC id out of range");
                a_credit_full: assert (!(credit_v_i && |(w_inc & w_full & ~w_dec)))
                    else $error("credit returned to full VC");
                a_credit_id_range: assert (!(credit_v_i && !(|w_credit_hit)))
                    else $error("credit VC id out of range");
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_floo_output_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_floo_output_port
// Description : Scoreboarded random/directed bench for the VC link output port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_floo_output_port;
    import floo_pkg::*;

    localparam int NUM_VC = 4;

    logic        clk;
    logic        rst_ni;
    logic        credit_v;
    logic [1:0]  credit_id;
    logic        send_v;
    logic [1:0]  send_vc_id;
    flit_t       send_flit;
    logic        data_v;
    flit_t       data;
    logic [3:0]  vc_credit_v;
    logic [3:0]  vc_credit_gt1;
    logic [3:0]  vc_idle;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    mcnt [NUM_VC];
    flit_t sb [$];
    int    due_q [$];
    int    vc_q [$];
    flit_t m_exp;

    floo_output_port #(
        .ASSERT_EN (1'b0)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .credit_v_i      (credit_v),
        .credit_id_i     (credit_id),
        .send_v_i        (send_v),
        .send_vc_id_i    (send_vc_id),
        .send_flit_i     (send_flit),
        .data_v_o        (data_v),
        .data_o          (data),
        .vc_credit_v_o   (vc_credit_v),
        .vc_credit_gt1_o (vc_credit_gt1),
        .vc_idle_o       (vc_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int depth_of(input int v);
        return (v == 0) ? 2 : 3;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_status(input string tag);
        logic [3:0] ev, eg, ei;
        for (int v = 0; v < NUM_VC; v++) begin
            ev[v] = (mcnt[v] != 0);
            eg[v] = (mcnt[v] >= 2);
            ei[v] = (mcnt[v] == depth_of(v));
        end
        check({tag, "_credit_v"}, 64'(vc_credit_v), 64'(ev));
        check({tag, "_gt1"}, 64'(vc_credit_gt1), 64'(eg));
        check({tag, "_idle"}, 64'(vc_idle), 64'(ei));
    endtask

    // One link cycle: drive, let the model decide the outcome, then check after the edge.
    task automatic apply(input string tag, input bit sv, input int sid, input bit cv,
                         input int cid, output bit ok);
        flit_t      f, e;
        logic [1:0] sid2;
        int         m;
        f.hdr.vc_id = 3'($urandom);
        f.hdr.dst   = 8'($urandom);
        f.hdr.last  = 1'($urandom);
        f.payload   = $urandom;
        sid2        = sid[1:0];
        send_v      = sv;
        send_vc_id  = sid2;
        send_flit   = f;
        credit_v    = cv;
        credit_id   = cid[1:0];
        ok = sv && (mcnt[sid] > 0);
        if (ok) begin
            e = f;
            e.hdr.vc_id[1:0] = sid2;
            sb.push_back(e);
        end
        for (int v = 0; v < NUM_VC; v++) begin
            m = mcnt[v] - ((ok && sid == v) ? 1 : 0) + ((cv && cid == v) ? 1 : 0);
            mcnt[v] = (m > depth_of(v)) ? depth_of(v) : m;
        end
        @(posedge clk);
        #1;
        cyc++;
        check({tag, "_data_v"}, 64'(data_v), 64'(ok));
        check_status(tag);
    endtask

    task automatic do_reset();
        rst_ni   = 1'b0;
        send_v   = 1'b0;
        credit_v = 1'b0;
        sb.delete();
        due_q.delete();
        vc_q.delete();
        for (int v = 0; v < NUM_VC; v++) mcnt[v] = depth_of(v);
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        check("reset_data_v", 64'(data_v), 64'(0));
        check_status("reset");
    endtask

    always @(negedge clk) begin
        if (rst_ni && data_v) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL link_flit: got unexpected flit %0h, expected none (cycle %0d)", data, cyc);
            end else begin
                m_exp = sb.pop_front();
                check("link_flit", 64'(data), 64'(m_exp));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit sv, cv;
        int vc, cid, pick;
        rst_ni     = 1'b0;
        send_v     = 1'b0;
        send_vc_id = '0;
        send_flit  = '0;
        credit_v   = 1'b0;
        credit_id  = '0;
        @(posedge clk);
        #1;
        do_reset();
        check("t1_credit_v_all", 64'(vc_credit_v), 64'(4'hf));
        check("t1_gt1_all", 64'(vc_credit_gt1), 64'(4'hf));
        check("t1_idle_all", 64'(vc_idle), 64'(4'hf));
        check("t1_data_zero", 64'(data), 64'(0));

        // Exhaust VC2, then recover it with returned credits
        for (int i = 0; i < 3; i++) apply("t2_send_vc2", 1, 2, 0, 0, ok);
        apply("t2_idle", 0, 0, 0, 0, ok);
        apply("t3_credit_vc2", 0, 0, 1, 2, ok);
        apply("t3_send_vc2", 1, 2, 0, 0, ok);
        check("t3_accepted", 64'(data_v), 64'(1));
        for (int i = 0; i < 3; i++) apply("t3_refill", 0, 0, 1, 2, ok);

        // Simultaneous send and credit on VC1 holding one credit
        for (int i = 0; i < 2; i++) apply("t4_send_vc1", 1, 1, 0, 0, ok);
        apply("t4_send_credit", 1, 1, 1, 1, ok);
        check("t4_vc1_credit", 64'(vc_credit_v[1]), 64'(1));
        for (int i = 0; i < 2; i++) apply("t4_refill", 0, 0, 1, 1, ok);

        // Illegal events: send without credit, credit to a full VC
        for (int i = 0; i < 2; i++) apply("t5_send_vc0", 1, 0, 0, 0, ok);
        apply("t5_drop", 1, 0, 0, 0, ok);
        check("t5_vc0_empty", 64'(vc_credit_v[0]), 64'(0));
        for (int i = 0; i < 2; i++) apply("t5_refill", 0, 0, 1, 0, ok);
        apply("t5_credit_full", 0, 0, 1, 3, ok);
        check("t5_vc3_idle", 64'(vc_idle[3]), 64'(1));

        // Random traffic with a downstream port returning credits after 1..5 cycles
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            vc = int'($urandom_range(0, NUM_VC - 1));
            sv = ($urandom_range(0, 3) != 0) && (mcnt[vc] > 0);
            cv = 1'b0;
            cid = 0;
            pick = -1;
            for (int k = 0; k < due_q.size(); k++) begin
                if (due_q[k] <= cyc && (pick < 0 || due_q[k] < due_q[pick])) pick = k;
            end
            if (pick >= 0) begin
                cv  = 1'b1;
                cid = vc_q[pick];
                due_q.delete(pick);
                vc_q.delete(pick);
            end
            begin
                int now;
                now = cyc;
                apply("t6_rand", sv, vc, cv, cid, ok);
                if (ok) begin
                    due_q.push_back(now + int'($urandom_range(1, 5)));
                    vc_q.push_back(vc);
                end
            end
        end

        // Drain outstanding credits within a bounded number of cycles
        for (int i = 0; i < 200 && due_q.size() > 0; i++) begin
            cv = 1'b0;
            cid = 0;
            pick = -1;
            for (int k = 0; k < due_q.size(); k++) begin
                if (due_q[k] <= cyc && (pick < 0 || due_q[k] < due_q[pick])) pick = k;
            end
            if (pick >= 0) begin
                cv  = 1'b1;
                cid = vc_q[pick];
                due_q.delete(pick);
                vc_q.delete(pick);
            end
            apply("t6_drain", 0, 0, cv, cid, ok);
        end
        check("t6_drain_done", 64'(due_q.size()), 64'(0));
        apply("t6_final", 0, 0, 0, 0, ok);
        check("t6_idle_all", 64'(vc_idle), 64'(4'hf));
        @(negedge clk);
        #1;
        check("t6_scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
